// File: rtl/controle_giro.sv
// Heading-command controller: pulses `girar` on the orientation tracker until
// `orientacao` matches the commanded heading. Optional GIRAR_STATS_EN adds total_giros.
module controle_giro #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned MAX_TURNS     = 3
) (
  input  logic       clockc3,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [0:2] cmd_heading,
  output logic       cmd_ready,
  input  logic [0:2] orientacao,
  output logic       girar,
  output logic       busy,
  output logic       done,
  output logic       erro,
  output logic [1:0] turns_taken
`ifdef GIRAR_STATS_EN
  ,
  output logic [7:0] total_giros
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PULSE,
    S_SETTLE,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [1:0] MAX_LD    = 2'(MAX_TURNS);

  state_e     state_q, state_d;
  logic [0:2] target_q;
  logic [1:0] turns_q;
  logic [3:0] settle_q;
  logic       girar_q;

  function automatic logic heading_ok(input logic [0:2] h);
    return (h == 3'b001) || (h == 3'b010) || (h == 3'b011) || (h == 3'b100);
  endfunction

  always_ff @(posedge clockc3) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) state_d = heading_ok(cmd_heading) ? S_CHECK : S_ERROR;
      end
      S_CHECK: begin
        if (!heading_ok(orientacao))  state_d = S_ERROR;
        else if (orientacao == target_q) state_d = S_DONE;
        else if (turns_q == MAX_LD)   state_d = S_ERROR;
        else                          state_d = S_PULSE;
      end
      S_PULSE:  state_d = S_SETTLE;
      S_SETTLE: if (settle_q <= 4'd1) state_d = S_CHECK;
      S_DONE:   state_d = S_IDLE;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase
  end

  // girar is registered from the next state so it is glitch-free and exactly one PULSE cycle wide
  always_ff @(posedge clockc3) begin
    if (reset) begin
      target_q <= '0;
      turns_q  <= '0;
      settle_q <= '0;
      girar_q  <= 1'b0;
    end else begin
      girar_q <= (state_d == S_PULSE);
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            target_q <= cmd_heading;
            turns_q  <= '0;
          end
        end
        S_PULSE: begin
          turns_q  <= turns_q + 2'd1;
          settle_q <= SETTLE_LD;
        end
        S_SETTLE: settle_q <= settle_q - 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_ready   = (state_q == S_IDLE);
    busy        = (state_q == S_CHECK) || (state_q == S_PULSE) || (state_q == S_SETTLE);
    done        = (state_q == S_DONE);
    erro        = (state_q == S_ERROR);
    girar       = girar_q;
    turns_taken = turns_q;
  end

`ifdef GIRAR_STATS_EN
  logic [7:0] total_q;

  always_ff @(posedge clockc3) begin
    if (reset)                           total_q <= '0;
    else if (girar_q && (total_q != '1)) total_q <= total_q + 8'd1;
  end

  assign total_giros = total_q;
`endif

endmodule

// File: tb/tb_controle_giro.sv
// Directed self-checking bench for controle_giro with a behavioural orientation tracker.
module tb_controle_giro;

  localparam logic [0:2] NORTE = 3'b001;
  localparam logic [0:2] OESTE = 3'b010;
  localparam logic [0:2] LESTE = 3'b011;
  localparam logic [0:2] SUL   = 3'b100;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [0:2] cmd_heading;
  logic       cmd_ready;
  logic [0:2] orientacao;
  logic       girar;
  logic       busy;
  logic       done;
  logic       erro;
  logic [1:0] turns_taken;
`ifdef GIRAR_STATS_EN
  logic [7:0] total_giros;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [0:2] trk;
  logic       stuck;

  int n_g;
  int g_cyc [4];
  int done_cyc, erro_cyc, ready_after;

  always #5 clk = ~clk;

  controle_giro #(.SETTLE_CYCLES(1), .MAX_TURNS(3)) dut (
    .clockc3     (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_heading (cmd_heading),
    .cmd_ready   (cmd_ready),
    .orientacao  (orientacao),
    .girar       (girar),
    .busy        (busy),
    .done        (done),
    .erro        (erro),
    .turns_taken (turns_taken)
`ifdef GIRAR_STATS_EN
    ,
    .total_giros (total_giros)
`endif
  );

  function automatic logic [0:2] rot(input logic [0:2] h);
    case (h)
      NORTE:   return OESTE;
      OESTE:   return SUL;
      SUL:     return LESTE;
      default: return NORTE;
    endcase
  endfunction

  function automatic logic [0:2] prev_h(input logic [0:2] h);
    case (h)
      NORTE:   return LESTE;
      OESTE:   return NORTE;
      SUL:     return OESTE;
      default: return SUL;
    endcase
  endfunction

  // Tracker reacts to a girar pulse on the following edge; stuck pins it at Oeste
  always @(posedge clk) begin
    if (reset)      trk <= NORTE;
    else if (girar) trk <= rot(trk);
  end
  assign orientacao = stuck ? OESTE : trk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge with the DUT in IDLE; that negedge starts cycle 0
  task automatic run_cmd(input logic [0:2] h, input int budget);
    cmd_heading = h;
    cmd_valid   = 1'b1;
    n_g = 0;
    for (int i = 0; i < 4; i++) g_cyc[i] = -1;
    done_cyc = -1; erro_cyc = -1; ready_after = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
      if (girar) begin
        if (n_g < 4) g_cyc[n_g] = c;
        n_g++;
      end
      if (done && done_cyc < 0) done_cyc = c;
      if (erro && erro_cyc < 0) erro_cyc = c;
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        ready_after = int'(cmd_ready);
        break;
      end
      if (erro_cyc >= 0) break;
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_heading = '0; stuck = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_girar", int'(girar), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_done",  int'(done), 0);
    check("rst_erro",  int'(erro), 0);
    check("rst_turns", int'(turns_taken), 0);
    @(negedge clk);
    reset = 1'b0;

    run_cmd(NORTE, 20);
    check("k0_done", done_cyc, 2);
    check("k0_pulses", n_g, 0);
    check("k0_turns", int'(turns_taken), 0);
    check("k0_ready", ready_after, 1);

    run_cmd(OESTE, 20);
    check("k1_g0", g_cyc[0], 2);
    check("k1_done", done_cyc, 5);
    check("k1_turns", int'(turns_taken), 1);

    run_cmd(LESTE, 20);
    check("k2_g1", g_cyc[1], 5);
    check("k2_done", done_cyc, 8);
    check("k2_turns", int'(turns_taken), 2);

    do_reset();
    run_cmd(LESTE, 20);
    check("k3_g0", g_cyc[0], 2);
    check("k3_g1", g_cyc[1], 5);
    check("k3_g2", g_cyc[2], 8);
    check("k3_pulses", n_g, 3);
    check("k3_done", done_cyc, 11);
    check("k3_turns", int'(turns_taken), 3);
    check("k3_ready", ready_after, 1);

    run_cmd(3'b111, 20);
    check("inv_erro_cyc", erro_cyc, 1);
    check("inv_ready", int'(cmd_ready), 0);
    check("inv_pulses", n_g, 0);
    cmd_heading = SUL; cmd_valid = 1'b1;
    repeat (4) @(negedge clk);
    cmd_valid = 1'b0;
    check("inv_sticky", int'(erro), 1);
    check("inv_ignore", int'(girar) + int'(busy), 0);
    do_reset();
    check("inv_rst_erro", int'(erro), 0);
    check("inv_rst_ready", int'(cmd_ready), 1);

    stuck = 1'b1;
    run_cmd(SUL, 30);
    check("stk_pulses", n_g, 3);
    check("stk_g2", g_cyc[2], 8);
    check("stk_erro_cyc", erro_cyc, 11);
    check("stk_done", done_cyc, -1);
    check("stk_turns", int'(turns_taken), 3);
    stuck = 1'b0;
    do_reset();

    begin : mid_reset
      int seen;
      seen = 0;
      cmd_heading = LESTE; cmd_valid = 1'b1;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (c == 1) cmd_valid = 1'b0;
        if (girar) begin
          seen = c;
          break;
        end
      end
      check("mid_girar_cyc", seen, 2);
      reset = 1'b1;
      @(negedge clk);
      check("mid_girar", int'(girar), 0);
      check("mid_ready", int'(cmd_ready), 1);
      check("mid_turns", int'(turns_taken), 0);
      check("mid_done", int'(done), 0);
      reset = 1'b0;
      run_cmd(OESTE, 20);
      check("mid_next_done", done_cyc, 5);
      check("mid_next_turns", int'(turns_taken), 1);
    end

`ifdef GIRAR_STATS_EN
    do_reset();
    check("st_rst", int'(total_giros), 0);
    for (int n = 0; n < 100; n++) begin
      run_cmd(prev_h(orientacao), 20);
      if (n == 0) check("st_first", int'(total_giros), 3);
    end
    check("st_turns", int'(turns_taken), 3);
    check("st_sat", int'(total_giros), 255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
